spi_ram_ctrl: RTL
=================

// Module: spi_ram_ctrl
// PURPOSE
//  Single-port RAM plus command decoder downstream of the SPI slave. Consumes 10-bit
//  command words (rx_data/rx_valid). Executes address-load, write and read commands.
//  Returns read bytes on tx_data/tx_valid for the slave to shift out on MISO.
// PARAMETERS
//  MEM_DEPTH  256  number of 8-bit RAM words
//  ADDR_SIZE  8    address width; MEM_DEPTH <= 2**ADDR_SIZE
// PORTS
//  clk       in   1          system clock, rising edge
//  rst       in   1          asynchronous reset, active-high
//  rx_data   in   10         command word: [9:8]=opcode, [7:0]=payload
//  rx_valid  in   1          level from slave; high while a complete word is held
//  tx_data   out  8          read byte for the slave
//  tx_valid  out  1          tx_data is valid; held until next accepted command
//  seq_err   out  1          sticky sequence-error flag (RAM_SEQ_ERR_EN only)
// BEHAVIOUR
//  Reset (async, rst=1): tx_data=0, tx_valid=0, seq_err=0, wr_addr=0, rd_addr=0,
//   state=S_IDLE, rx_valid_q=0. RAM contents are not reset.
//  Accept: a command is accepted only on a rising edge of rx_valid
//   (rx_valid & ~rx_valid_q). That is one command per word, however long rx_valid stays high.
//  Opcodes, executed in the acceptance cycle:
//   2'b00 WR_ADDR: wr_addr<=payload; state->S_WADDR.
//   2'b01 WR_DATA: if wr_addr loaded since reset: mem[wr_addr]<=payload,
//         wr_addr<=wr_addr+1, wrapping MEM_DEPTH-1->0. Otherwise ignored.
//   2'b10 RD_ADDR: rd_addr<=payload; state->S_RADDR.
//   2'b11 RD_DATA: if rd_addr loaded since reset: tx_data<=mem[rd_addr] registered;
//         tx_valid=1 from the next cycle; rd_addr<=rd_addr+1 with the same wrap.
//         Otherwise ignored; tx_valid stays 0.
//  Payload >= MEM_DEPTH on WR_ADDR/RD_ADDR: address wraps modulo MEM_DEPTH.
//  tx_valid drops to 0 in the cycle any later command is accepted. It also drops on rst.
//   tx_data keeps its last value until the next RD_DATA.
//  FSM (sequencing only): S_IDLE, S_WADDR, S_RADDR, S_BOTH.
//   S_IDLE -WR_ADDR-> S_WADDR; S_IDLE -RD_ADDR-> S_RADDR.
//   S_WADDR -RD_ADDR-> S_BOTH; S_RADDR -WR_ADDR-> S_BOTH.
//   In all other cases the state holds.
//   WR_DATA is legal in S_WADDR/S_BOTH. RD_DATA is legal in S_RADDR/S_BOTH.
//  Single port: at most one RAM access per cycle, guaranteed by the one-command-per-edge rule.
//  Reset mid-transaction: state, addresses and tx_valid clear immediately. No RAM write
//   is committed in a cycle where rst is high.
// CONFIGURATION
//  RAM_SEQ_ERR_EN defined: seq_err is set, and stays set until rst, on any of:
//   WR_DATA outside S_WADDR/S_BOTH; RD_DATA outside S_RADDR/S_BOTH.
//  RAM_SEQ_ERR_EN undefined: the seq_err port is absent. Illegal commands are still
//   silently ignored.
// STRUCTURE
//  Package spi_ram_pkg: opcode localparams (OP_WR_ADDR..OP_RD_DATA), FSM state encoding.
//  Sub-module spi_ram_mem: the sync-write/sync-read single-port array (clk, we, addr, din, dout).
//  Decoder, FSM and edge detect stay in spi_ram_ctrl.
// TESTING
//  T1 rst=1 mid-run -> all outputs 0 same cycle (async); state S_IDLE after release.
//  T2 cmd 0x005 then 0x1A5 -> mem[5]=0xA5; then 0x205, 0x3xx -> tx_data=0xA5,
//     tx_valid=1 one cycle after the RD_DATA edge.
//  T3 hold rx_valid high 20 cycles on 0x1A5 -> exactly one write; wr_addr advances by 1 only.
//  T4 wr_addr=0xFF, WR_DATA 0x11, then WR_DATA 0x22 (MEM_DEPTH=256) -> mem[0xFF]=0x11,
//     mem[0x00]=0x22 (wrap).
//  T5 after reset, first cmd 0x3xx -> tx_valid stays 0; seq_err=1 with RAM_SEQ_ERR_EN;
//     no seq_err port without it.
//  T6 tx_valid high, then new 0x000 accepted -> tx_valid=0 that cycle; tx_data unchanged.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: opcodes and sequencing-FSM states shared by the SPI RAM controller.
package spi_ram_pkg;
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_WADDR, S_RADDR, S_BOTH} state_t;
endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: single-port 8-bit RAM, synchronous write and synchronous (read-before-write) read.
module spi_ram_mem #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [7:0]           din,
  output logic [7:0]           dout
);
  logic [7:0] mem [MEM_DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command decoder, sequencing FSM and RAM for 10-bit SPI command words.
// Define RAM_SEQ_ERR_EN to add the sticky seq_err output for out-of-sequence data commands.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid
`ifdef RAM_SEQ_ERR_EN
  , output logic     seq_err
`endif
);
  localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);
  function automatic logic [ADDR_SIZE-1:0] inc(input logic [ADDR_SIZE-1:0] a);
    return a == LAST ? '0 : a + 1'b1;
  endfunction
  function automatic logic [ADDR_SIZE-1:0] wrap(input logic [7:0] p);
    return ADDR_SIZE'(32'(p) % MEM_DEPTH);
  endfunction
  state_t state;
  logic rx_valid_q, acc, wr_ok, rd_ok, we;
  logic [1:0] op;
  logic [7:0] pl, dout;
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  assign op = rx_data[9:8];
  assign pl = rx_data[7:0];
  assign acc = rx_valid & ~rx_valid_q;
  assign wr_ok = state inside {S_WADDR, S_BOTH};
  assign rd_ok = state inside {S_RADDR, S_BOTH};
  assign we = acc & (op == OP_WR_DATA) & wr_ok & ~rst;
  // Outside write cycles the RAM continuously prefetches mem[rd_addr]; accepted commands are
  // at least two cycles apart, so dout is always current when RD_DATA arrives.
  spi_ram_mem #(.MEM_DEPTH(MEM_DEPTH), .ADDR_SIZE(ADDR_SIZE)) u_mem (
    .clk (clk),
    .we  (we),
    .addr(we ? wr_addr : rd_addr),
    .din (pl),
    .dout(dout)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rx_valid_q <= 1'b0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
`ifdef RAM_SEQ_ERR_EN
      seq_err    <= 1'b0;
`endif
    end else begin
      rx_valid_q <= rx_valid;
      if (acc) begin
        tx_valid <= 1'b0;
        case (op)
          OP_WR_ADDR: begin
            wr_addr <= wrap(pl);
            state   <= state == S_IDLE ? S_WADDR : state == S_RADDR ? S_BOTH : state;
          end
          OP_WR_DATA: if (wr_ok) wr_addr <= inc(wr_addr);
          OP_RD_ADDR: begin
            rd_addr <= wrap(pl);
            state   <= state == S_IDLE ? S_RADDR : state == S_WADDR ? S_BOTH : state;
          end
          default: if (rd_ok) begin
            tx_data  <= dout;
            tx_valid <= 1'b1;
            rd_addr  <= inc(rd_addr);
          end
        endcase
`ifdef RAM_SEQ_ERR_EN
        if ((op == OP_WR_DATA && !wr_ok) || (op == OP_RD_DATA && !rd_ok)) seq_err <= 1'b1;
`endif
      end
    end
  end
endmodule
